regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_wsel.sv | 26 ++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Build with REGFILE_MP_BYPASS_EN defined to enable write-first read bypass.
package regfile_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_A_WIDTH    = 5;
    localparam int DEF_D_WIDTH    = 32;
    localparam int DEF_FLAG_REG   = 9;
    localparam int DEF_RESULT_REG = 10;

endpackage

// File: rtl/regfile_mp_wsel.sv
// Per-address write-port arbitration: highest-indexed enabled port hitting addr wins.
module regfile_mp_wsel #(
    parameter int NWR     = 2,
    parameter int A_WIDTH = 5,
    parameter int IW      = 1
) (
    input  logic [NWR-1:0]              we,
    input  logic [NWR-1:0][A_WIDTH-1:0] wa,
    input  logic [A_WIDTH-1:0]          addr,
    output logic                        hit,
    output logic [IW-1:0]               idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Ascending scan so later (higher) ports overwrite earlier matches.
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && wa[i] == addr) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing start-up sequence and trigger flag.
// Optional feature: REGFILE_MP_BYPASS_EN adds same-cycle write-first read bypass.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int D_WIDTH    = DEF_D_WIDTH,
    parameter int NRD        = 2,
    parameter int NWR        = 2,
    parameter int FLAG_REG   = DEF_FLAG_REG,
    parameter int RESULT_REG = DEF_RESULT_REG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NWR-1:0]              we,
    input  logic [NWR-1:0][A_WIDTH-1:0] wa,
    input  logic [NWR-1:0][D_WIDTH-1:0] wd,
    input  logic [NRD-1:0][A_WIDTH-1:0] ra,
    output logic [NRD-1:0][D_WIDTH-1:0] rd,
    input  logic                        trigger,
    output logic [D_WIDTH-1:0]          a0,
    output logic                        ready
);

    localparam int NREG = 2 ** A_WIDTH;
    localparam int IW   = (NWR > 1) ? $clog2(NWR) : 1;

    state_t               state, state_nxt;
    logic [A_WIDTH-1:0]   clr_cnt;
    logic                 pending;
    logic                 run_wr;
    logic [NWR-1:0]       we_eff;
    logic [NREG-1:0]      hit_v;
    logic [NREG-1:0][IW-1:0] idx_v;
    logic [D_WIDTH-1:0]   mem [NREG];

    assign ready  = (state == RUN);
    assign run_wr = (state == RUN) && !rst;
    assign we_eff = run_wr ? we : '0;

    // One arbiter per register; its result drives both the array write and the bypass.
    for (genvar a = 0; a < NREG; a++) begin : g_wsel
        regfile_mp_wsel #(.NWR(NWR), .A_WIDTH(A_WIDTH), .IW(IW)) u_wsel (
            .we   (we_eff),
            .wa   (wa),
            .addr (A_WIDTH'(a)),
            .hit  (hit_v[a]),
            .idx  (idx_v[a])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == {A_WIDTH{1'b1}})
            state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
            pending <= 1'b0;
        end else begin
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (state == CLEAR && trigger) pending <= 1'b1;
            else if (state == RUN)         pending <= 1'b0;
        end
    end

    // No array reset: the CLEAR walk is the only initialisation.
    always_ff @(posedge clk) begin
        for (int a = 0; a < NREG; a++) begin
            if (state == CLEAR) begin
                if (clr_cnt == A_WIDTH'(a)) mem[a] <= '0;
            end else if (run_wr && a != 0) begin
                if (hit_v[a])
                    mem[a] <= wd[idx_v[a]];
                else if (a == FLAG_REG && (trigger || pending))
                    mem[a] <= D_WIDTH'(1);
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
`ifdef REGFILE_MP_BYPASS_EN
        assign rd[p] = (!ready || ra[p] == '0) ? '0 :
                       hit_v[ra[p]] ? wd[idx_v[ra[p]]] : mem[ra[p]];
`else
        assign rd[p] = (!ready || ra[p] == '0) ? '0 : mem[ra[p]];
`endif
    end

    localparam logic [A_WIDTH-1:0] RES_A = A_WIDTH'(RESULT_REG);

`ifdef REGFILE_MP_BYPASS_EN
    assign a0 = (!ready || RES_A == '0) ? '0 :
                hit_v[RES_A] ? wd[idx_v[RES_A]] : mem[RES_A];
`else
    assign a0 = (!ready || RES_A == '0) ? '0 : mem[RES_A];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a plain array reference model.
module tb_regfile_mp;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       we = '0;
    logic [1:0][4:0]  wa = '0;
    logic [1:0][31:0] wd = '0;
    logic [1:0][4:0]  ra = '0;
    logic [1:0][31:0] rd;
    logic             trigger = 1'b0;
    logic [31:0]      a0;
    logic             ready;

    int total = 0;
    int bad   = 0;

    bit          m_run  = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_mem [32];

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd), .trigger(trigger), .a0(a0), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] addr);
        logic [31:0] v;
        if (!m_run || addr == 0) return 32'h0;
        v = m_mem[addr];
`ifdef REGFILE_MP_BYPASS_EN
        for (int i = 0; i < 2; i++)
            if (we[i] && wa[i] == addr) v = wd[i];
`endif
        return v;
    endfunction

    // Reference semantics of one clock edge in RUN.
    task automatic model_edge();
        bit flag_written;
        flag_written = 1'b0;
        if (!m_run) return;
        for (int i = 0; i < 2; i++) begin
            if (we[i]) begin
                if (wa[i] != 0) m_mem[wa[i]] = wd[i];
                if (wa[i] == 9) flag_written = 1'b1;
            end
        end
        if ((trigger || m_pend) && !flag_written) m_mem[9] = 32'h1;
        m_pend = 1'b0;
    endtask

    task automatic idle();
        we = '0;
        trigger = 1'b0;
    endtask

    task automatic step(input string tag);
        logic [31:0] e;
        @(negedge clk);
        total++;
        if (ready !== m_run) begin
            bad++;
            $display("FAIL %s ready got=%b exp=%b", tag, ready, m_run);
        end
        for (int p = 0; p < 2; p++) begin
            e = exp_rd(ra[p]);
            total++;
            if (rd[p] !== e) begin
                bad++;
                $display("FAIL %s rd[%0d] ra=%0d got=%h exp=%h", tag, p, ra[p], rd[p], e);
            end
        end
        e = exp_rd(5'd10);
        total++;
        if (a0 !== e) begin
            bad++;
            $display("FAIL %s a0 got=%h exp=%h", tag, a0, e);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input bit trig);
        int n;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_run = 1'b0;
        m_pend = 1'b0;
        n = 0;
        while (n < 200) begin
            trigger = trig && (n == 3);
            ra[1] = 5'($urandom_range(0, 31));
            @(negedge clk);
            if (ready === 1'b1) break;
            total++;
            if (ready !== 1'b0 || rd[0] !== 32'h0 || rd[1] !== 32'h0 || a0 !== 32'h0) begin
                bad++;
                $display("FAIL clear_out cyc=%0d ready=%b rd0=%h rd1=%h a0=%h", n, ready, rd[0], rd[1], a0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        trigger = 1'b0;
        total++;
        if (n != 32) begin
            bad++;
            $display("FAIL clear_len got=%0d exp=32", n);
        end
        // Still at the negedge of the first RUN cycle: FLAG_REG not yet set.
        if (trig) begin
            total++;
            if (rd[0] !== 32'h0) begin
                bad++;
                $display("FAIL pend_early rd0 got=%h exp=0", rd[0]);
            end
        end
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_run = 1'b1;
        m_pend = trig;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        ra = {5'd3, 5'd31};
        step("reset_zero");
    endtask

    task automatic test_priority();
        we = 2'b11;
        wa = {5'd5, 5'd5};
        wd = {32'h1234_5678, 32'hAAAA_0000};
        step("prio_wr");
        idle();
        ra[0] = 5'd5;
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL prio rd0 got=%h exp=12345678", rd[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        we = 2'b01;
        wa[0] = 5'd0;
        wd[0] = 32'hFFFF_FFFF;
        ra = {5'd0, 5'd0};
        step("zero_wr");
        idle();
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h0 || rd[1] !== 32'h0) begin
            bad++;
            $display("FAIL zero_rd got=%h/%h exp=0", rd[0], rd[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        logic [31:0] e;
`ifdef REGFILE_MP_BYPASS_EN
        e = 32'hDEAD_BEEF;
`else
        e = 32'h0;
`endif
        we = 2'b01;
        wa[0] = 5'd10;
        wd[0] = 32'hDEAD_BEEF;
        ra[1] = 5'd10;
        @(negedge clk);
        total++;
        if (rd[1] !== e || a0 !== e) begin
            bad++;
            $display("FAIL bypass rd1=%h a0=%h exp=%h", rd[1], a0, e);
        end
        @(posedge clk);
        model_edge();
        #1;
        idle();
        step("bypass_after");
    endtask

    task automatic test_trigger();
        ra[0] = 5'd9;
        do_reset(1'b1);
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h1) begin
            bad++;
            $display("FAIL pend_set rd0 got=%h exp=1", rd[0]);
        end
        @(posedge clk);
        #1;
        trigger = 1'b1;
        we = 2'b01;
        wa[0] = 5'd9;
        wd[0] = 32'h7;
        step("trig_port");
        idle();
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h7) begin
            bad++;
            $display("FAIL trig_port_win rd0 got=%h exp=7", rd[0]);
        end
        @(posedge clk);
        #1;
        wa[0] = 5'd9;
        wd[0] = 32'h0;
        we = 2'b01;
        step("flag_clr");
        idle();
        trigger = 1'b1;
        step("trig_run");
        trigger = 1'b0;
        step("trig_run_chk");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we = 2'($urandom);
            // Narrow address range so port collisions and re-reads are frequent.
            wa = {5'($urandom_range(0, 12)), 5'($urandom_range(0, 12))};
            wd = {32'($urandom), 32'($urandom)};
            ra = {5'($urandom_range(0, 12)), 5'($urandom_range(0, 12))};
            trigger = ($urandom_range(0, 9) == 0);
            step("random");
        end
        idle();
    endtask

    task automatic test_rst_mid_run();
        we = 2'b01;
        wa[0] = 5'd12;
        wd[0] = 32'h55;
        step("r12_wr");
        idle();
        ra[0] = 5'd12;
        step("r12_rd");
        do_reset(1'b0);
        ra[0] = 5'd12;
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst r12 got=%h exp=0", rd[0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_priority();
        test_zero();
        test_bypass();
        test_trigger();
        test_random();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
